// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register hazard scoreboard for the ID stage.
// Tracks load-use countdowns and outstanding long ops, and requests a stall on hazards.
module id_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MAX_LONG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic                 issue_rs_used,
    input  logic                 issue_rt_used,
    input  logic [ADDR_W-1:0]    issue_rs,
    input  logic [ADDR_W-1:0]    issue_rt,
    input  logic                 issue_we,
    input  logic [ADDR_W-1:0]    issue_waddr,
    input  logic [1:0]           issue_kind,
    input  logic                 long_done,
    input  logic [ADDR_W-1:0]    long_done_addr,
    output logic                 stallreq,
    output logic [2**ADDR_W-1:0] busy_vec,
    output logic [2:0]           long_cnt
);
    localparam int NREG = 2**ADDR_W;

    logic [2:0]      cnt_q [NREG];
    logic [2:0]      cnt_d [NREG];
    logic [NREG-1:0] lng_q, lng_d;
    logic [2:0]      long_cnt_q, long_cnt_d;
    logic            raw, waw, full, accept, wr, ld, lo, dn;

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NREG; r++) busy_vec[r] = (cnt_q[r] != 3'd0) | lng_q[r];
    end

    assign raw      = (issue_rs_used & busy_vec[issue_rs]) | (issue_rt_used & busy_vec[issue_rt]);
    assign waw      = issue_we & busy_vec[issue_waddr] & (issue_waddr != '0);
    assign full     = (issue_kind == 2'd2) & (long_cnt_q == 3'(MAX_LONG)) & ~long_done;
    assign stallreq = issue_valid & ~flush & (raw | waw | full);
    assign accept   = issue_valid & ~flush & ~stallreq;
    assign wr       = accept & issue_we & (issue_waddr != '0);
    assign ld       = wr & (issue_kind == 2'd1);
    assign lo       = wr & (issue_kind == 2'd2);
    // lng_q[0] is never set, so a completion to r0 is naturally ignored
    assign dn       = long_done & lng_q[long_done_addr];
    assign long_cnt = long_cnt_q;

    always_comb begin
        lng_d = lng_q;
        if (dn) lng_d[long_done_addr] = 1'b0;
        if (lo) lng_d[issue_waddr] = 1'b1;
        for (int r = 0; r < NREG; r++)
            cnt_d[r] = (ld && issue_waddr == ADDR_W'(r)) ? 3'(LOAD_LAT) : cnt_q[r] - 3'(cnt_q[r] != 3'd0);
        long_cnt_d = long_cnt_q + 3'(lo) - 3'(dn);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '{default: '0};
            lng_q      <= '0;
            long_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            lng_q      <= lng_d;
            long_cnt_q <= long_cnt_d;
        end
    end
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed and random checks of two scoreboard instances (LOAD_LAT 1 and 3)
// against a ready-time / outstanding-set reference model.
module tb_id_scoreboard;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0, rst = 1'b1;
    logic          flush, issue_valid, issue_rs_used, issue_rt_used, issue_we, long_done;
    logic [AW-1:0] issue_rs, issue_rt, issue_waddr, long_done_addr;
    logic [1:0]    issue_kind;
    logic          st0, st1;
    logic [NR-1:0] bv0, bv1;
    logic [2:0]    lc0, lc1;

    int vec = 0, errs = 0;
    int cyc = 0;
    int rdy [2][NR];
    bit lng [2][NR];
    int lat [2] = '{1, 3};

    id_scoreboard u1 (.clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
        .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used), .issue_rs(issue_rs),
        .issue_rt(issue_rt), .issue_we(issue_we), .issue_waddr(issue_waddr), .issue_kind(issue_kind),
        .long_done(long_done), .long_done_addr(long_done_addr), .stallreq(st0), .busy_vec(bv0),
        .long_cnt(lc0));

    id_scoreboard #(.LOAD_LAT(3)) u3 (.clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
        .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used), .issue_rs(issue_rs),
        .issue_rt(issue_rt), .issue_we(issue_we), .issue_waddr(issue_waddr), .issue_kind(issue_kind),
        .long_done(long_done), .long_done_addr(long_done_addr), .stallreq(st1), .busy_vec(bv1),
        .long_cnt(lc1));

    always #5 clk = ~clk;

    function automatic bit mbusy(int i, int r);
        return r != 0 && (cyc < rdy[i][r] || lng[i][r]);
    endfunction

    function automatic int mcnt(int i);
        int n = 0;
        for (int r = 0; r < NR; r++) n += int'(lng[i][r]);
        return n;
    endfunction

    function automatic bit mstall(int i);
        bit raw, waw, full;
        raw  = (issue_rs_used && mbusy(i, int'(issue_rs))) || (issue_rt_used && mbusy(i, int'(issue_rt)));
        waw  = issue_we && mbusy(i, int'(issue_waddr));
        full = issue_kind == 2'd2 && mcnt(i) == 2 && !long_done;
        return issue_valid && !flush && (raw || waw || full);
    endfunction

    task automatic mreset();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < NR; r++) begin
                rdy[i][r] = 0;
                lng[i][r] = 0;
            end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {flush, issue_valid, issue_rs_used, issue_rt_used, issue_we, long_done} = '0;
        {issue_rs, issue_rt, issue_waddr, long_done_addr} = '0;
        issue_kind = 2'd0;
    endtask

    task automatic settle_check();
        logic [NR-1:0] eb;
        #1;
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < NR; r++) eb[r] = mbusy(i, r);
            chk($sformatf("stallreq[%0d]", i), 32'(i == 0 ? st0 : st1), 32'(mstall(i)));
            chk($sformatf("busy_vec[%0d]", i), i == 0 ? bv0 : bv1, eb);
            chk($sformatf("long_cnt[%0d]", i), 32'(i == 0 ? lc0 : lc1), 32'(mcnt(i)));
        end
    endtask

    task automatic advance();
        for (int i = 0; i < 2; i++) begin
            bit acc;
            acc = issue_valid && !flush && !mstall(i);
            if (long_done && lng[i][long_done_addr]) lng[i][long_done_addr] = 0;
            if (acc && issue_we && issue_waddr != '0) begin
                if (issue_kind == 2'd1) rdy[i][issue_waddr] = cyc + 1 + lat[i];
                if (issue_kind == 2'd2) lng[i][issue_waddr] = 1;
            end
        end
        @(posedge clk);
        cyc++;
        #2;
    endtask

    task automatic issue(logic v, logic [1:0] k, logic we, int wa, logic rsu, int rs);
        idle();
        issue_valid = v; issue_kind = k; issue_we = we; issue_waddr = AW'(wa);
        issue_rs_used = rsu; issue_rs = AW'(rs);
    endtask

    initial begin
        idle();
        mreset();
        #7;
        issue(1, 2'd0, 1, 3, 1, 3);
        settle_check();
        chk("reset_stall", 32'(st0), 32'd0);
        rst = 1'b0;
        idle();
        advance();
        // load-use: LAT=1 busy for one cycle, LAT=3 for three
        issue(1, 2'd1, 1, 8, 0, 0); settle_check(); advance();
        issue(1, 2'd0, 0, 0, 1, 8); settle_check();
        chk("lat1_stall_c1", 32'(st0), 32'd1); advance();
        settle_check();
        chk("lat1_stall_c2", 32'(st0), 32'd0);
        chk("lat1_busy8_c2", 32'(bv0[8]), 32'd0); advance();
        issue(1, 2'd1, 1, 0, 0, 0); settle_check(); advance();
        issue(1, 2'd0, 0, 0, 1, 0); settle_check();
        chk("r0_stall", 32'(st0), 32'd0);
        chk("r0_busy", bv1, 32'd0); advance();
        idle(); repeat (3) begin settle_check(); advance(); end
        // long-op capacity, with a same-cycle completion freeing a slot
        issue(1, 2'd2, 1, 3, 0, 0); settle_check(); advance();
        issue(1, 2'd2, 1, 4, 0, 0); settle_check(); advance();
        issue(1, 2'd2, 1, 5, 0, 0); settle_check();
        chk("full_stall", 32'(st0), 32'd1); advance();
        long_done = 1; long_done_addr = 5'd3; settle_check();
        chk("full_done_stall", 32'(st0), 32'd0); advance();
        idle(); settle_check();
        chk("full_done_cnt", 32'(lc0), 32'd2);
        // WAW on outstanding long destination
        issue(1, 2'd2, 1, 6, 0, 0); long_done = 1; long_done_addr = 5'd4; settle_check(); advance();
        issue(1, 2'd0, 1, 6, 0, 0); settle_check();
        chk("waw_stall", 32'(st0), 32'd1); advance();
        long_done = 1; long_done_addr = 5'd6; settle_check(); advance();
        issue(1, 2'd0, 1, 6, 0, 0); settle_check();
        chk("waw_release", 32'(st0), 32'd0); advance();
        // flush kills the issuing load
        issue(1, 2'd1, 1, 9, 0, 0); flush = 1; settle_check();
        chk("flush_stall", 32'(st1), 32'd0); advance();
        idle(); settle_check();
        chk("flush_busy9", 32'(bv1[9]), 32'd0); advance();
        // async reset mid-countdown with a long op outstanding
        issue(1, 2'd1, 1, 10, 0, 0); settle_check(); advance();
        idle(); settle_check(); advance();
        issue(1, 2'd0, 0, 0, 1, 10); settle_check();
        chk("pre_rst_busy10", 32'(bv1[10]), 32'd1);
        rst = 1'b1; #1;
        chk("arst_busy", bv1, 32'd0);
        chk("arst_cnt", 32'(lc1), 32'd0);
        chk("arst_cnt0", 32'(lc0), 32'd0);
        rst = 1'b0;
        mreset();
        settle_check();
        chk("post_rst_stall", 32'(st1), 32'd0); advance();
        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 500; n++) begin
            idle();
            issue_valid   = ($urandom % 4) != 0;
            flush         = ($urandom % 10) == 0;
            issue_rs_used = $urandom % 2;
            issue_rt_used = $urandom % 2;
            issue_rs      = AW'($urandom_range(0, 7));
            issue_rt      = AW'($urandom_range(0, 7));
            issue_we      = ($urandom % 4) != 0;
            issue_waddr   = AW'($urandom_range(0, 7));
            issue_kind    = 2'($urandom % 4);
            long_done_addr = AW'($urandom_range(0, 7));
            long_done     = ($urandom % 3) == 0;
            for (int i = 0; i < 2; i++)
                if (!lng[i][long_done_addr] && mcnt(i) == 2) long_done = 0;
            settle_check();
            advance();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
